mux_serializer_16: RTL and testbench
====================================

// Module: mux_serializer_16
// PURPOSE
//  Parallel-to-serial front end for the 16:1 mux. Accepts a 16-bit word via valid/ready,
//  registers it, and sweeps a 4-bit select counter so the mux emits one bit per accepted
//  beat on a valid/ready serial port. Pulses done after the last bit.
//  Sits directly upstream of Sixteen_to_One_Mux and owns its d and s inputs.
// PARAMETERS
//  MSB_FIRST  0  0: emit bit 0..15 (sel counts up); 1: emit bit 15..0 (sel counts down)
// PORTS
//  clk        in   1   single clock, all state updates on rising edge
//  rst        in   1   asynchronous, active-high reset
//  load_valid in   1   upstream word is present on load_data
//  load_ready out  1   block can accept a word (high only in IDLE)
//  load_data  in   16  word to serialise
//  sel        out  4   current mux select (registered); also drives internal mux s
//  ser_out    out  1   serial bit = load word[sel]; forced 0 when ser_valid=0
//  ser_valid  out  1   ser_out holds a valid bit
//  ser_ready  in   1   downstream accepts ser_out this cycle
//  done       out  1   one-cycle pulse: last bit accepted
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, data_reg=0, sel=0 (MSB_FIRST=1: 15), ser_valid=0,
//   ser_out=0, done=0, load_ready=1. Reset mid-word discards the word; no done pulse.
//  FSM states: IDLE, SHIFT, DONE (2-bit encoding).
//  IDLE: load_ready=1. On load_valid&&load_ready: data_reg<=load_data, sel<=FIRST,
//   go to SHIFT. FIRST=0 (MSB_FIRST=0) or 15 (MSB_FIRST=1).
//  SHIFT: ser_valid=1, ser_out=mux(data_reg,sel). Beat = ser_valid&&ser_ready.
//   Beat and sel!=LAST: sel<=sel+1 (or -1). Beat and sel==LAST: go to DONE.
//   LAST=15 (MSB_FIRST=0) or 0 (MSB_FIRST=1).
//   ser_ready=0 stalls: sel, data_reg, ser_out held bit-stable, no limit on stall length.
//  DONE: done=1 for exactly one cycle, ser_valid=0, sel<=FIRST, then go to IDLE.
//  load_valid outside IDLE is ignored (load_ready=0); the word is neither captured nor lost
//   upstream because no handshake occurred.
//  Latency: word accepted at edge N gives first bit valid in cycle N+1. With ser_ready held
//   high, bits occupy N+1..N+16, done is high in N+17, and the next word is accepted
//   at N+18 at the earliest.
//  Counter is 4 bits. Wrap never occurs because the LAST compare precedes the increment.
//  ser_out is combinational from registered data_reg/sel/state only, so no path from
//   load_* or ser_ready to ser_out is permitted.
//  No X propagation: don't-care bits of load_data do not reach ser_out for unselected sel.
// STRUCTURE
//  Shared defines file (`include): state encodings S_IDLE=2'd0, S_SHIFT=2'd1,
//   S_DONE=2'd2; WORD_W=16; SEL_W=4.
//  One sub-module: Sixteen_to_One_Mux instance (port order d, s, y). Connections:
//   d=data_reg, s=sel, y gated by ser_valid to form ser_out.
//  Remaining logic is the FSM, select counter and data register in this module.
// TESTING
//  1 Reset: assert rst mid-sim -> load_ready=1, ser_valid=0, ser_out=0, sel=0, done=0
//    asynchronously, before the next edge.
//  2 LSB-first: load 16'hA5C3, ser_ready=1 -> ser_out stream 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1;
//    done pulses 17 cycles after accept.
//  3 MSB_FIRST=1: load 16'h8001 -> ser_out 1, then fourteen 0s, then 1; sel runs 15..0.
//  4 Backpressure: load 16'hFFFF, drop ser_ready for 3 cycles at sel=7 -> sel stays 7,
//    ser_valid stays 1, 16 beats total, done once.
//  5 Load during SHIFT: pulse load_valid with 16'h0000 mid-word -> ignored, original word
//    completes; new word accepted only after DONE.
//  6 Reset mid-word at sel=9 -> no done pulse; next load 16'h0001 serialises correctly
//    from sel=0.

Source files
------------

// File: rtl/mux_serializer_16_pkg.sv
// Shared types, widths and select-sequencing helpers for the 16-bit serializer slice.
package mux_serializer_16_pkg;

  localparam int WORD_W = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic [SEL_W-1:0] first_sel(input logic msb_first);
    first_sel = msb_first ? 4'd15 : 4'd0;
  endfunction

  function automatic logic [SEL_W-1:0] last_sel(input logic msb_first);
    last_sel = msb_first ? 4'd0 : 4'd15;
  endfunction

  function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] cur,
                                                input logic msb_first);
    step_sel = msb_first ? (cur - 4'd1) : (cur + 4'd1);
  endfunction

endpackage

// File: rtl/mux_serializer_16_mux.sv
// Plain 16:1 bit mux; only the selected bit of d reaches y.
module Sixteen_to_One_Mux
  import mux_serializer_16_pkg::*;
(
  input  logic [WORD_W-1:0] d,
  input  logic [SEL_W-1:0]  s,
  output logic              y
);

  // select one bit of the word
  always_comb begin
    y = d[s];
  end

endmodule

// File: rtl/mux_serializer_16.sv
// Parallel-to-serial front end: captures a word, sweeps the mux select one bit per
// accepted serial beat, then pulses done for a single cycle.
module mux_serializer_16
  import mux_serializer_16_pkg::*;
#(
  parameter logic MSB_FIRST = 1'b0
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WORD_W-1:0] load_data,
  output logic [SEL_W-1:0]  sel,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              done
);

  localparam logic [SEL_W-1:0] FIRST_SEL = first_sel(MSB_FIRST);
  localparam logic [SEL_W-1:0] LAST_SEL  = last_sel(MSB_FIRST);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [WORD_W-1:0]   r_data;
  logic [WORD_W-1:0]   w_data_nxt;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic                w_mux_y;
  logic                w_shift;
  logic                w_beat;

  // decode status purely from registered state so no input reaches ser_out
  always_comb begin
    w_shift = (r_state == S_SHIFT);
    w_beat  = w_shift && ser_ready;
  end

  // next-state, select counter and data register update
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_data_nxt  = r_data;
    case (r_state)
      S_IDLE: begin
        if (load_valid) begin
          w_data_nxt  = load_data;
          w_sel_nxt   = FIRST_SEL;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_beat) begin
          // compare against LAST before stepping, so the counter never wraps
          if (r_sel == LAST_SEL) begin
            w_state_nxt = S_DONE;
          end else begin
            w_sel_nxt = step_sel(r_sel, MSB_FIRST);
          end
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE: begin
        w_sel_nxt   = FIRST_SEL;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_sel_nxt   = FIRST_SEL;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // state, select and data registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= FIRST_SEL;
      r_data  <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_data  <= w_data_nxt;
    end
  end

  Sixteen_to_One_Mux u_mux (
    .d (r_data),
    .s (r_sel),
    .y (w_mux_y)
  );

  // output decode, all derived from registers
  always_comb begin
    load_ready = (r_state == S_IDLE);
    ser_valid  = w_shift;
    ser_out    = w_mux_y & w_shift;
    done       = (r_state == S_DONE);
    sel        = r_sel;
  end

endmodule

// File: tb/tb_mux_serializer_16.sv
// Runs an LSB-first and an MSB-first serializer in lockstep against a bit-index model.
module tb_mux_serializer_16;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_data;
  logic        ser_ready;

  logic        ld_rdy_l, ser_out_l, ser_vld_l, done_l;
  logic [3:0]  sel_l;
  logic        ld_rdy_m, ser_out_m, ser_vld_m, done_m;
  logic [3:0]  sel_m;

  int n_checks;
  int n_errors;

  mux_serializer_16 #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ld_rdy_l),
    .load_data(load_data), .sel(sel_l), .ser_out(ser_out_l), .ser_valid(ser_vld_l),
    .ser_ready(ser_ready), .done(done_l)
  );

  mux_serializer_16 #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ld_rdy_m),
    .load_data(load_data), .sel(sel_m), .ser_out(ser_out_m), .ser_valid(ser_vld_m),
    .ser_ready(ser_ready), .done(done_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ldrdy_l"}, 32'(ld_rdy_l), 32'd1);
    chk({tag, "_ldrdy_m"}, 32'(ld_rdy_m), 32'd1);
    chk({tag, "_vld_l"}, 32'(ser_vld_l), 32'd0);
    chk({tag, "_vld_m"}, 32'(ser_vld_m), 32'd0);
    chk({tag, "_out_l"}, 32'(ser_out_l), 32'd0);
    chk({tag, "_out_m"}, 32'(ser_out_m), 32'd0);
    chk({tag, "_done_l"}, 32'(done_l), 32'd0);
    chk({tag, "_done_m"}, 32'(done_m), 32'd0);
    chk({tag, "_sel_l"}, 32'(sel_l), 32'd0);
    chk({tag, "_sel_m"}, 32'(sel_m), 32'd15);
  endtask

  // Beat k of a word is bit k (LSB-first) or bit 15-k (MSB-first).
  task automatic run_word(input logic [15:0] w, input int ready_pct, input int stall_at,
                          input int abort_at, input bit poke_load);
    int  k;
    int  cyc;
    int  wait_n;
    int  stall_n;
    bit  rdy;
    wait_n  = 0;
    stall_n = 0;
    @(negedge clk);
    while (!ld_rdy_l && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    chk("wait_load_ready_l", 32'(ld_rdy_l), 32'd1);
    chk("wait_load_ready_m", 32'(ld_rdy_m), 32'd1);
    load_valid = 1'b1;
    load_data  = w;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = 16'($urandom);
    k   = 0;
    cyc = 0;
    while (k < 16 && cyc < 300) begin
      cyc++;
      if (k == abort_at) begin
        #2 rst = 1'b1;
        #1 chk_idle_outputs("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        ser_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("post_rst_no_done_l", 32'(done_l), 32'd0);
          chk("post_rst_no_done_m", 32'(done_m), 32'd0);
          chk("post_rst_idle_l", 32'(ld_rdy_l), 32'd1);
        end
        return;
      end
      rdy = ($urandom_range(0, 99) < ready_pct);
      if (k == stall_at && stall_n < 3) begin
        rdy = 1'b0;
        stall_n++;
      end
      ser_ready = rdy;
      if (poke_load && k >= 5 && k <= 6) begin
        load_valid = 1'b1;
        load_data  = 16'h0000;
      end else begin
        load_valid = 1'b0;
      end
      @(negedge clk);
      chk("shift_vld_l", 32'(ser_vld_l), 32'd1);
      chk("shift_vld_m", 32'(ser_vld_m), 32'd1);
      chk("shift_sel_l", 32'(sel_l), 32'(k));
      chk("shift_sel_m", 32'(sel_m), 32'(15 - k));
      chk("shift_bit_l", 32'(ser_out_l), 32'(w[k]));
      chk("shift_bit_m", 32'(ser_out_m), 32'(w[15 - k]));
      chk("shift_done_l", 32'(done_l), 32'd0);
      chk("shift_ldrdy_m", 32'(ld_rdy_m), 32'd0);
      @(posedge clk);
      #1;
      if (rdy) k++;
    end
    load_valid = 1'b0;
    ser_ready  = 1'($urandom);
    chk("beat_count", 32'(k), 32'd16);
    if (ready_pct == 100 && stall_at < 0) begin
      chk("done_latency", 32'(cyc + 1), 32'd17);
    end
    if (stall_at >= 0) begin
      chk("stall_cycles", 32'(cyc), 32'd19);
    end
    @(negedge clk);
    chk("done_pulse_l", 32'(done_l), 32'd1);
    chk("done_pulse_m", 32'(done_m), 32'd1);
    chk("done_vld_l", 32'(ser_vld_l), 32'd0);
    chk("done_out_m", 32'(ser_out_m), 32'd0);
    chk("done_ldrdy_l", 32'(ld_rdy_l), 32'd0);
    @(negedge clk);
    chk_idle_outputs("after_done");
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    ser_ready  = 1'b0;
    #3 chk_idle_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    run_word(16'hA5C3, 100, -1, -1, 1'b0);
    run_word(16'h8001, 100, -1, -1, 1'b0);
    run_word(16'hFFFF, 100, 7, -1, 1'b0);
    run_word(16'h1234, 100, -1, -1, 1'b1);
    run_word(16'hBEEF, 100, -1, 9, 1'b0);
    run_word(16'h0001, 100, -1, -1, 1'b0);
    for (int n = 0; n < 25; n++) begin
      run_word(16'($urandom), int'($urandom_range(30, 100)), -1, -1,
               1'($urandom_range(0, 1)));
    end
    run_word(16'h5A5A, 60, -1, int'($urandom_range(1, 14)), 1'b0);
    run_word(16'hC0DE, 100, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
